// File: rtl/song_reader_pkg.sv
// -----------------------------------------------------------------------------
// song_reader_pkg
// Shared definitions for the song reader block:
//   - default widths for note/duration fields, note index and song select
//   - ROM word width ({note, duration})
//   - end-of-song marker value carried in the duration field
//   - FSM state encoding used by song_reader
// Optional feature macro used by song_reader: SONG_READER_LOOP_EN
// -----------------------------------------------------------------------------
package song_reader_pkg;

    localparam int NOTE_W_DEF = 6;                 // note code / duration width
    localparam int IDX_W_DEF  = 5;                 // 32 notes per song
    localparam int SONG_W_DEF = 2;                 // 4 songs
    localparam int ROM_W_DEF  = 2 * NOTE_W_DEF;    // {note, duration}

    // A duration of zero never describes a playable note, so it doubles as
    // the end-of-song marker.
    localparam int END_MARKER = 0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_ROM  = 3'd2,
        S_ISSUE     = 3'd3,
        S_WAIT_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/song_reader_song_rom.sv
// -----------------------------------------------------------------------------
// song_rom
// Synchronous song ROM with one cycle of read latency.
// Ports:
//   clk   in   system clock
//   addr  in   {song, note index}, SONG_W+IDX_W bits
//   data  out  {note, duration}, 2*NOTE_W bits, valid one clock after addr
// Contents (index i within the song):
//   song 0: i<4  -> note 10+3i, duration i+1; end marker at i=4
//   song 1: i<12 -> note 20+i,  duration 2+(i mod 3); end marker at i=12
//   song 2: all 32 entries -> note (5i+3) mod 64, duration 1+(i mod 4); no marker
//   song 3: i<20 -> note 40+i (rest on every fourth entry), duration 4;
//           end marker at i=20
//   any other address reads as {0, END_MARKER}.
// -----------------------------------------------------------------------------
module song_rom
    import song_reader_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int SONG_W = SONG_W_DEF
)
(
    input  logic                    clk,
    input  logic [SONG_W+IDX_W-1:0] addr,
    output logic [2*NOTE_W-1:0]     data
);

    // Contents are generated from the song rules above; every address is a
    // constant expression, so this folds into a plain lookup table.
    function automatic logic [2*NOTE_W-1:0] rom_lookup(
        input logic [SONG_W-1:0] s,
        input logic [IDX_W-1:0]  i
    );
        int n;
        int d;
        int ii;
        ii = int'(i);
        n  = 0;
        d  = END_MARKER;
        case (int'(s))
            0: begin
                if (ii < 4) begin
                    n = 10 + 3 * ii;
                    d = ii + 1;
                end
            end
            1: begin
                if (ii < 12) begin
                    n = 20 + ii;
                    d = 2 + (ii % 3);
                end
            end
            2: begin
                n = (5 * ii + 3) % 64;
                d = 1 + (ii % 4);
            end
            3: begin
                if (ii < 20) begin
                    n = ((ii % 4) == 3) ? 0 : 40 + ii;
                    d = 4;
                end
            end
            default: begin
                n = 0;
                d = END_MARKER;
            end
        endcase
        return {NOTE_W'(n), NOTE_W'(d)};
    endfunction

    // NOTE: the ROM read register is deliberately left without reset; it is
    // storage whose value is only consumed after a FETCH has loaded it, and
    // resetting memory-style registers costs routing for no behavioural gain.
    always_ff @(posedge clk) begin
        data <= rom_lookup(addr[SONG_W+IDX_W-1:IDX_W], addr[IDX_W-1:0]);
    end

endmodule

// File: rtl/song_reader.sv
// -----------------------------------------------------------------------------
// song_reader
// Steps through a stored song one note at a time, handing each
// {note, duration} pair to a note player and waiting for it to finish.
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   asynchronous active-low reset
//   play       in   level: 1 = advance through the song, 0 = pause
//   song       in   song select, sampled only when leaving IDLE
//   note_done  in   one-cycle pulse from the note player
//   note       out  note code (frequency ROM address), 0 = rest
//   duration   out  note length in beats
//   new_note   out  one-cycle pulse: note/duration are valid
//   song_done  out  one-cycle pulse: song finished
// Build option:
//   SONG_READER_LOOP_EN  when defined, the end of a song restarts it at
//                        entry 0 instead of pulsing song_done and idling.
// -----------------------------------------------------------------------------
module song_reader
    import song_reader_pkg::*;
#(
    parameter int NOTE_W = NOTE_W_DEF,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int SONG_W = SONG_W_DEF
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic [SONG_W-1:0] song,
    input  logic              note_done,
    output logic [NOTE_W-1:0] note,
    output logic [NOTE_W-1:0] duration,
    output logic              new_note,
    output logic              song_done
);

`ifdef SONG_READER_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    state_t              state;
    logic [SONG_W-1:0]   song_q;
    logic [IDX_W-1:0]    idx;
    logic [2*NOTE_W-1:0] rom_data;
    logic [NOTE_W-1:0]   rom_note;
    logic [NOTE_W-1:0]   rom_dur;
    logic                rom_end;
    logic                idx_last;
    logic                dur_end;

    assign {rom_note, rom_dur} = rom_data;
    assign rom_end  = (rom_dur == NOTE_W'(END_MARKER));
    assign dur_end  = (duration == NOTE_W'(END_MARKER));
    assign idx_last = &idx;

    // The address is simply the live {song_q, idx}; it is stable throughout
    // FETCH, so the word read at the end of FETCH is ready in WAIT_ROM.
    song_rom #(
        .NOTE_W (NOTE_W),
        .IDX_W  (IDX_W),
        .SONG_W (SONG_W)
    ) u_song_rom (
        .clk  (clk),
        .addr ({song_q, idx}),
        .data (rom_data)
    );

    // Pulses are registered on the edge that enters ISSUE (or IDLE), so
    // new_note appears exactly three clocks after play rises in IDLE and
    // each pulse lasts one clock even when play freezes the FSM in ISSUE.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            song_q    <= '0;
            idx       <= '0;
            note      <= '0;
            duration  <= '0;
            new_note  <= 1'b0;
            song_done <= 1'b0;
        end else begin
            new_note  <= 1'b0;
            song_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (play) begin
                        song_q <= song;
                        idx    <= '0;
                        state  <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (play) begin
                        state <= S_WAIT_ROM;
                    end
                end

                S_WAIT_ROM: begin
                    if (play) begin
                        note     <= rom_note;
                        duration <= rom_dur;
                        state    <= S_ISSUE;
                        if (!rom_end) begin
                            new_note <= 1'b1;
                        end else if (!LOOP_EN) begin
                            song_done <= 1'b1;
                        end
                    end
                end

                S_ISSUE: begin
                    // The pulse already went out on entry; leaving only
                    // decides where to go next.
                    if (play) begin
                        if (!dur_end) begin
                            state <= S_WAIT_DONE;
                        end else if (LOOP_EN) begin
                            idx   <= '0;
                            state <= S_FETCH;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end

                S_WAIT_DONE: begin
                    // note_done is honoured even while paused; with play low
                    // the FSM then parks in FETCH on the next entry.
                    if (note_done) begin
                        idx <= idx + 1'b1;
                        if (idx_last && !LOOP_EN) begin
                            song_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_song_reader.sv
// -----------------------------------------------------------------------------
// tb_song_reader
// Self-checking bench for song_reader. A timeline model of the reader
// predicts every output on every cycle; directed scenarios pin the model
// with hand-computed values, then a randomized run exercises play, song,
// note_done and reset freely.
// -----------------------------------------------------------------------------
module tb_song_reader;

`ifdef SONG_READER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [1:0] song;
    logic       note_done;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       song_done;

    logic spur_nd;
    logic resp_nd;
    logic resp_en;
    logic chk_en;

    int n_vec  = 0;
    int n_err  = 0;
    int n_new  = 0;
    int n_done = 0;

    assign note_done = spur_nd | resp_nd;

    always #5 clk = ~clk;

    song_reader dut (
        .clk       (clk),
        .reset     (reset),
        .play      (play),
        .song      (song),
        .note_done (note_done),
        .note      (note),
        .duration  (duration),
        .new_note  (new_note),
        .song_done (song_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Song contents as a list of rules: returns note n and duration d of
    // entry i of song s (d == 0 marks the end of the song).
    function automatic void song_word(input int s, input int i, output int n, output int d);
        n = 0;
        d = 0;
        if (s == 0 && i <= 3) begin
            n = 10 + i + i + i;
            d = i + 1;
        end else if (s == 1 && i <= 11) begin
            n = 20 + i;
            d = 2 + i - 3 * (i / 3);
        end else if (s == 2) begin
            n = (5 * i + 3) & 63;
            d = 1 + (i & 3);
        end else if (s == 3 && i <= 19) begin
            n = ((i & 3) == 3) ? 0 : 40 + i;
            d = 4;
        end
    endfunction

    // ---------------- timeline model ----------------
    // The reader is either idle, counting play-enabled clocks until the next
    // entry is presented (lead), holding a just-presented entry for one
    // play-enabled clock, or waiting for the player to finish the note.
    typedef enum int {PH_IDLE, PH_LEAD, PH_HOLD, PH_WAIT} phase_t;
    phase_t m_phase = PH_IDLE;
    int     m_song  = 0;
    int     m_idx   = 0;
    int     m_lead  = 0;
    bit     m_end   = 1'b0;
    int     x_note  = 0;
    int     x_dur   = 0;
    bit     x_new   = 1'b0;
    bit     x_done  = 1'b0;

    always @(posedge clk or negedge reset) begin
        int wn;
        int wd;
        if (!reset) begin
            m_phase = PH_IDLE;
            m_idx   = 0;
            m_song  = 0;
            x_note  = 0;
            x_dur   = 0;
            x_new   = 1'b0;
            x_done  = 1'b0;
        end else begin
            x_new  = 1'b0;
            x_done = 1'b0;
            case (m_phase)
                PH_IDLE: if (play) begin
                    m_song  = int'(song);
                    m_idx   = 0;
                    m_lead  = 2;
                    m_phase = PH_LEAD;
                end
                PH_LEAD: if (play) begin
                    m_lead = m_lead - 1;
                    if (m_lead == 0) begin
                        song_word(m_song, m_idx, wn, wd);
                        x_note  = wn;
                        x_dur   = wd;
                        m_end   = (wd == 0);
                        x_new   = !m_end;
                        x_done  = m_end && !LOOP;
                        m_phase = PH_HOLD;
                    end
                end
                PH_HOLD: if (play) begin
                    if (!m_end) m_phase = PH_WAIT;
                    else if (LOOP) begin
                        m_idx   = 0;
                        m_lead  = 2;
                        m_phase = PH_LEAD;
                    end else m_phase = PH_IDLE;
                end
                default: if (note_done) begin
                    if (m_idx == 31 && !LOOP) begin
                        x_done  = 1'b1;
                        m_phase = PH_IDLE;
                    end else begin
                        m_idx   = (m_idx + 1) % 32;
                        m_lead  = 2;
                        m_phase = PH_LEAD;
                    end
                end
            endcase
        end
    end

    // ---------------- compare + pulse counters ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("new_note", new_note, x_new);
            check("song_done", song_done, x_done);
            check("note", note, x_note);
            check("duration", duration, x_dur);
            check("pulse_exclusive", new_note & song_done, 0);
        end
        if (new_note) n_new++;
        if (song_done) n_done++;
    end

    // ---------------- note player stand-in ----------------
    // Answers each new_note with a one-cycle note_done five clocks later.
    int resp_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            resp_cnt = 0;
            resp_nd  = 1'b0;
        end else begin
            resp_nd = 1'b0;
            if (resp_en && new_note) resp_cnt = 5;
            else if (resp_cnt > 0) begin
                resp_cnt = resp_cnt - 1;
                if (resp_cnt == 0) resp_nd = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        play    = 1'b0;
        spur_nd = 1'b0;
        resp_en = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Counts clocks until new_note is seen (bounded by limit).
    task automatic wait_new(output int n, input int limit);
        n = 0;
        do begin
            tick();
            n++;
        end while (!new_note && n < limit);
    endtask

    task automatic run_until_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < limit && !seen; c++) begin
            tick();
            if (song_done) seen = 1'b1;
        end
        play = 1'b0;
    endtask

    initial begin
        int n;
        int b_new;
        int b_done;
        int k;
        bit seen;

        reset   = 1'b0;
        play    = 1'b0;
        song    = 2'd0;
        spur_nd = 1'b0;
        resp_en = 1'b0;
        chk_en  = 1'b0;
        tick();
        tick();
        chk_en = 1'b1;

        // Reset state.
        check("rst_note", note, 0);
        check("rst_duration", duration, 0);
        check("rst_new_note", new_note, 0);
        check("rst_song_done", song_done, 0);

        // Start latency and first entry of song 1, then pause in WAIT_DONE.
        reset = 1'b1;
        song  = 2'd1;
        play  = 1'b1;
        wait_new(n, 10);
        check("start_latency", n, 3);
        check("s1_e0_note", note, 20);
        check("s1_e0_duration", duration, 2);
        tick();
        play    = 1'b0;
        spur_nd = 1'b1;
        tick();
        spur_nd = 1'b0;
        b_new   = n_new;
        repeat (6) tick();
        check("paused_no_new_note", n_new - b_new, 0);
        play = 1'b1;
        wait_new(n, 10);
        check("resume_latency", n, 2);
        check("s1_e1_note", note, 21);
        check("s1_e1_duration", duration, 3);

        // Song 0: marker at entry 4.
        do_reset();
        b_new  = n_new;
        b_done = n_done;
        resp_en = 1'b1;
        song    = 2'd0;
        play    = 1'b1;
        run_until_done(200, seen);
        tick();
        check("s0_done_seen", seen, 1);
        check("s0_note_count", n_new - b_new, 4);
        check("s0_done_count", n_done - b_done, 1);

        // Song 2: no marker, index wraps after entry 31.
        do_reset();
        b_new   = n_new;
        b_done  = n_done;
        resp_en = 1'b1;
        song    = 2'd2;
        play    = 1'b1;
`ifdef SONG_READER_LOOP_EN
        k = 0;
        for (int c = 0; c < 800 && k < 33; c++) begin
            tick();
            if (new_note) k++;
        end
        play = 1'b0;
        check("s2_loop_33rd_note", note, 3);
        check("s2_loop_33rd_duration", duration, 1);
        check("s2_loop_note_count", k, 33);
        check("s2_loop_done_count", n_done - b_done, 0);
`else
        run_until_done(800, seen);
        tick();
        check("s2_done_seen", seen, 1);
        check("s2_note_count", n_new - b_new, 32);
        check("s2_done_count", n_done - b_done, 1);
`endif

        // Reset during WAIT_DONE of the third note.
        do_reset();
        resp_en = 1'b1;
        song    = 2'd1;
        play    = 1'b1;
        k = 0;
        for (int c = 0; c < 100 && k < 3; c++) begin
            tick();
            if (new_note) k++;
        end
        check("third_note_reached", k, 3);
        tick();
        tick();
        b_done = n_done;
        reset  = 1'b0;
        #1;
        check("midnote_rst_note", note, 0);
        check("midnote_rst_duration", duration, 0);
        check("midnote_rst_new_note", new_note, 0);
        check("midnote_rst_song_done", song_done, 0);
        tick();
        reset = 1'b1;
        wait_new(n, 10);
        check("restart_latency", n, 3);
        check("restart_note", note, 20);
        check("restart_duration", duration, 2);
        check("midnote_no_song_done", n_done - b_done, 0);

        // Spurious note_done in IDLE, FETCH, WAIT_ROM and ISSUE.
        do_reset();
        song    = 2'd1;
        spur_nd = 1'b1;
        tick();
        tick();
        b_new = n_new;
        play  = 1'b1;
        repeat (4) tick();
        spur_nd = 1'b0;
        repeat (4) tick();
        check("spurious_note_count", n_new - b_new, 1);
        check("spurious_note_entry", note, 20);
        spur_nd = 1'b1;
        tick();
        spur_nd = 1'b0;
        wait_new(n, 10);
        check("spurious_next_latency", n, 2);
        check("spurious_next_note", note, 21);

        // Randomized run.
        do_reset();
        resp_en = 1'b1;
        play    = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) play = ~play;
            song    = 2'($urandom);
            spur_nd = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                tick();
                reset = 1'b1;
            end
            tick();
        end
        play    = 1'b0;
        spur_nd = 1'b0;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
